intr_ctrl: RTL and testbench

Machine-level external interrupt controller driving the core's single `intr` input, the source side of the trap unit's interrupt path.
- Latches edge events from NSRC peripheral lines into pending bits and masks them with an enable register.
- Raises `intr` and arbitrates by fixed priority, with lowest index winning.
- The trap handler claims and completes through a small register port.
- Guarantees a fresh low-to-high `intr` edge per claimable event, because the core traps only on a rising edge of `intr`.

---
 rtl/intr_ctrl.sv | 150 +++++++++++++++
 tb/tb_intr_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Machine-level external interrupt controller: edge-latched pending bits, enable mask,
// fixed-priority claim/complete port and an intr output that re-edges once per claimable event.
module intr_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            reg_wr_en,
  input  logic            reg_rd_en,
  input  logic [3:0]      reg_addr,
  input  logic [31:0]     reg_wdat,
  output logic [31:0]     reg_rdat,
  output logic            reg_rd_vld,
  output logic            intr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_PENDING = 4'h0;
  localparam logic [3:0] ADDR_ENABLE  = 4'h4;
  localparam logic [3:0] ADDR_CLAIM   = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_intr;
  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_enable;
  logic [4:0]      r_claimed_id;
  logic [31:0]     r_rdat;
  logic            r_rd_vld;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_cand;
  logic [NSRC-1:0] w_win_oh;
  logic [NSRC-1:0] w_clr_mask;
  logic [NSRC-1:0] w_pending_nxt;
  logic [4:0]      w_win_id;
  logic            w_claim_ok;
  logic            w_complete_ok;
  logic            w_en_wr;
  logic            w_busy;
  logic [31:0]     w_rdat;
  logic            w_unused_wdat;

  assign w_rise = src_irq & ~r_src_d;
  assign w_cand = r_pending & r_enable;

  // Scan from the top so the lowest set index is the last (winning) assignment.
  always_comb begin
    w_win_id = '0;
    w_win_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_id = 5'(i + 1);
        w_win_oh = NSRC'(1) << i;
      end
    end
  end

  assign w_claim_ok    = reg_rd_en && (reg_addr == ADDR_CLAIM) &&
                         ((r_state == IDLE) || (r_state == ASSERT)) && (w_win_id != 5'd0);
  assign w_complete_ok = reg_wr_en && (reg_addr == ADDR_CLAIM) &&
                         (r_state == BUSY) && (reg_wdat[4:0] == r_claimed_id);
  assign w_en_wr       = reg_wr_en && (reg_addr == ADDR_ENABLE);
  assign w_busy        = (r_state == BUSY) || (r_state == GAP);

  // A fresh edge on the bit being claimed re-sets it: a new event, not a lost one.
  assign w_clr_mask    = w_claim_ok ? w_win_oh : '0;
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_rise;

  always_comb begin
    w_rdat = '0;
    case (reg_addr)
      ADDR_PENDING: w_rdat = {{(32-NSRC){1'b0}}, r_pending};
      ADDR_ENABLE:  w_rdat = {{(32-NSRC){1'b0}}, r_enable};
      ADDR_CLAIM:   w_rdat = w_claim_ok ? {27'd0, w_win_id} : 32'd0;
      ADDR_STATUS:  w_rdat = {15'd0, r_intr, 3'd0, r_claimed_id, 7'd0, w_busy};
      default:      w_rdat = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_claim_ok)              w_state_nxt = BUSY;
        else if (w_win_id != 5'd0)   w_state_nxt = ASSERT;
      end
      ASSERT: begin
        if (w_claim_ok)              w_state_nxt = BUSY;
        else if (w_win_id == 5'd0)   w_state_nxt = IDLE;
      end
      BUSY: begin
        if (w_complete_ok)           w_state_nxt = GAP;
      end
      GAP:                           w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // intr is a flop mirroring state==ASSERT so the core sees a clean edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_intr  <= (w_state_nxt == ASSERT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_d      <= '0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_claimed_id <= '0;
      r_rdat       <= '0;
      r_rd_vld     <= 1'b0;
    end else begin
      r_src_d   <= src_irq;
      r_pending <= w_pending_nxt;
      if (w_en_wr) begin
        r_enable <= reg_wdat[NSRC-1:0];
      end
      if (w_claim_ok) begin
        r_claimed_id <= w_win_id;
      end else if (w_complete_ok) begin
        r_claimed_id <= '0;
      end
      r_rd_vld <= reg_rd_en;
      r_rdat   <= reg_rd_en ? w_rdat : 32'd0;
    end
  end

  assign w_unused_wdat = ^reg_wdat;

  assign reg_rdat   = r_rdat;
  assign reg_rd_vld = r_rd_vld;
  assign intr       = r_intr;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: register reads push expected data, a negedge monitor
// pops and compares on reg_rd_vld; intr level is checked directly against hand-derived values.
module tb_intr_ctrl;

  localparam int NSRC = 8;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src_irq;
  logic            reg_wr_en;
  logic            reg_rd_en;
  logic [3:0]      reg_addr;
  logic [31:0]     reg_wdat;
  logic [31:0]     reg_rdat;
  logic            reg_rd_vld;
  logic            intr;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  intr_ctrl #(.NSRC(NSRC)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_addr   (reg_addr),
    .reg_wdat   (reg_wdat),
    .reg_rdat   (reg_rdat),
    .reg_rd_vld (reg_rd_vld),
    .intr       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
    $fatal(1, "watchdog");
  end

  // Monitor: compares every read response against the oldest queued expectation.
  always @(negedge clk) begin
    if (reg_rd_vld) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_vld: got rdat=0x%08h, wanted no response", reg_rdat);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (reg_rdat !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, wanted 0x%08h", t, reg_rdat, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string t);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    reg_rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdat  = d;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic chk(input string t, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, wanted %0b", t, got, want);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    src_irq   = '0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr  = '0;
    reg_wdat  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_intr", intr, 1'b0);
    chk("reset_rd_vld", reg_rd_vld, 1'b0);
    n_tests++;
    if (reg_rdat !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rdat: got 0x%08h, wanted 0x00000000", reg_rdat);
    end
    rd(4'h4, 32'h0, "reset_enable");
    rd(4'hC, 32'h0, "reset_status");

    // 1: single source, interrupt-driven claim
    wr(4'h4, 32'hFF);
    src_irq = 8'h08;
    tick();
    src_irq = 8'h00;
    chk("t1_intr_not_yet", intr, 1'b0);
    rd(4'h0, 32'h08, "t1_pending");
    chk("t1_intr_high", intr, 1'b1);
    rd(4'h8, 32'd4, "t1_claim");
    chk("t1_intr_low_after_claim", intr, 1'b0);
    rd(4'h0, 32'h00, "t1_pending_cleared");
    rd(4'hC, 32'h0000_0401, "t1_status");
    wr(4'h8, 32'd4);
    tick();

    // 2: two simultaneous sources, priority and GAP
    src_irq = 8'h24;
    tick();
    src_irq = 8'h00;
    tick();
    chk("t2_intr_high", intr, 1'b1);
    rd(4'h8, 32'd3, "t2_claim_3");
    chk("t2_intr_low_busy", intr, 1'b0);
    wr(4'h8, 32'd3);
    chk("t2_gap_low1", intr, 1'b0);
    tick();
    chk("t2_gap_low2", intr, 1'b0);
    tick();
    chk("t2_reassert", intr, 1'b1);
    rd(4'h8, 32'd6, "t2_claim_6");
    rd(4'h8, 32'd0, "t2_claim_busy");
    wr(4'h8, 32'd6);
    tick();

    // 3: pending without enable, enable raise and drop
    wr(4'h4, 32'h00);
    src_irq = 8'h02;
    tick();
    src_irq = 8'h00;
    tick();
    chk("t3_masked_intr", intr, 1'b0);
    rd(4'h0, 32'h02, "t3_pending");
    wr(4'h4, 32'h02);
    chk("t3_intr_not_yet", intr, 1'b0);
    tick();
    chk("t3_intr_high", intr, 1'b1);
    wr(4'h4, 32'h00);
    tick();
    chk("t3_intr_dropped", intr, 1'b0);
    rd(4'h0, 32'h02, "t3_pending_kept");
    // polled claim straight from IDLE
    wr(4'h4, 32'h02);
    rd(4'h8, 32'd2, "t3_polled_claim");
    chk("t3_polled_no_intr", intr, 1'b0);
    wr(4'h8, 32'd2);
    tick();

    // 4: mismatched complete and claim while busy
    wr(4'h4, 32'hFF);
    src_irq = 8'h08;
    tick();
    src_irq = 8'h00;
    tick();
    rd(4'h8, 32'd4, "t4_claim");
    wr(4'h8, 32'd2);
    rd(4'hC, 32'h0000_0401, "t4_status_still_busy");
    rd(4'h8, 32'd0, "t4_claim_busy");
    wr(4'h8, 32'd4);
    rd(4'hC, 32'h0000_0001, "t4_status_gap");
    rd(4'hC, 32'h0000_0000, "t4_status_idle");

    // 5: new edge on the claimed bit in the claim cycle
    src_irq = 8'h08;
    tick();
    src_irq = 8'h00;
    tick();
    src_irq = 8'h08;
    rd(4'h8, 32'd4, "t5_claim");
    src_irq = 8'h00;
    rd(4'h0, 32'h08, "t5_pending_kept");
    wr(4'h8, 32'd4);
    tick();
    tick();
    chk("t5_reassert", intr, 1'b1);
    rd(4'h8, 32'd4, "t5_claim_again");

    // 6: reset while busy with other sources pending
    src_irq = 8'h30;
    tick();
    src_irq = 8'h00;
    tick();
    rd(4'h0, 32'h30, "t6_pending_before_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_intr", intr, 1'b0);
    chk("t6_rd_vld", reg_rd_vld, 1'b0);
    rd(4'h4, 32'h0, "t6_enable");
    rd(4'h0, 32'h0, "t6_pending");
    rd(4'hC, 32'h0, "t6_status");
    rd(4'h8, 32'h0, "t6_claim");

    // register-map corner cases
    wr(4'h0, 32'hFF);
    rd(4'h0, 32'h0, "ro_pending_write");
    rd(4'h2, 32'h0, "unmapped_read");
    wr(4'h4, 32'hFFFF_FF00);
    rd(4'h4, 32'h0, "enable_upper_bits");
    reg_rd_en = 1'b1;
    reg_wr_en = 1'b1;
    reg_addr  = 4'h4;
    reg_wdat  = 32'h55;
    exp_q.push_back(32'h0);
    tag_q.push_back("rd_wr_same_cycle");
    tick();
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    rd(4'h4, 32'h55, "enable_after_rdwr");

    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_responses: got %0d outstanding, wanted 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
